// File: rtl/int_result_buff.sv
// int_result_buff
//   Result staging FIFO that sits directly after the integer add/sub/convert
//   unit. Each valid result (data + pipeline token) is captured in issue order.
//   The head is presented first-word-fall-through to write-back with a
//   valid/ready handshake. A registered stall goes back to the issue stage.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high; clears pointers, count, overflow
//   I_Flush     synchronous flush; discards all entries, keeps O_Overflow
//   I_Valid     result valid from the integer unit
//   I_Data      result data
//   I_Token     result token
//   O_Stall     upstream must not assert I_Valid next cycle
//   O_Overflow  sticky; a valid result arrived while the buffer was full
//   O_Valid     head entry valid toward write-back
//   O_Data      head data, zero when idle
//   O_Token     head token, zero when idle
//   I_Ready     write-back accepts the head this cycle
//   O_Count     current occupancy
module int_result_buff #(
    parameter int  DEPTH      = 4,
    parameter int  WIDTH_DATA = 32,
    parameter type TYPE       = logic [7:0]
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     I_Flush,
    input  logic                     I_Valid,
    input  logic [WIDTH_DATA-1:0]    I_Data,
    input  TYPE                      I_Token,
    output logic                     O_Stall,
    output logic                     O_Overflow,
    output logic                     O_Valid,
    output logic [WIDTH_DATA-1:0]    O_Data,
    output TYPE                      O_Token,
    input  logic                     I_Ready,
    output logic [$clog2(DEPTH):0]   O_Count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH_DATA-1:0] data_mem  [DEPTH];
    TYPE                   token_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;

    logic full;
    logic rd;
    logic wr;

    assign full = (count == (AW+1)'(DEPTH));
    assign rd   = O_Valid & I_Ready;
    // A pop in the same cycle frees the slot a full buffer needs for the push.
    assign wr   = I_Valid & (~full | rd);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (I_Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            if (wr && !rd)      count <= count + (AW+1)'(1);
            else if (rd && !wr) count <= count - (AW+1)'(1);
            if (I_Valid && !wr) overflow <= 1'b1;
        end
    end

    // Storage is never cleared; only the pointers define what is live.
    always_ff @(posedge clock) begin
        if (wr && !reset && !I_Flush) begin
            data_mem[wr_ptr]  <= I_Data;
            token_mem[wr_ptr] <= I_Token;
        end
    end

    assign O_Valid    = (count != '0);
    assign O_Data     = O_Valid ? data_mem[rd_ptr]  : '0;
    assign O_Token    = O_Valid ? token_mem[rd_ptr] : '0;
    // One slot of slack covers the result already in flight from the unit.
    assign O_Stall    = (count >= (AW+1)'(DEPTH - 1));
    assign O_Overflow = overflow;
    assign O_Count    = count;

endmodule
